pf_lanectrl_pause_sync_multi: RTL and testbench

Multi-lane, parametrised synchroniser and pulse shaper for the HS_IO_CLK_PAUSE requests that drive the lane controllers of the DDR PHY block. Each lane's request passes through a configurable-depth synchroniser and then a per-lane state machine. The state machine enforces a minimum pause width and a minimum inter-pause gap. An optional ganged mode pauses all lanes together. Sticky status reports requests that had to be stretched.

---
 rtl/pf_lanectrl_pause_sync_multi.sv | 253 +++++++++++++++++++++++++
 tb/tb_pf_lanectrl_pause_sync_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pf_lanectrl_pause_sync_multi.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_sync_multi
//
// Purpose:
//   Synchronises the HS_IO_CLK_PAUSE requests for the DDR PHY lane
//   controllers and shapes each into a clean pause. Every pause is held
//   high for at least MIN_PULSE cycles. Every two pauses on a lane are
//   separated by at least MIN_GAP low cycles. A sticky status bit
//   records each request that had to be stretched. With GANG=1, a single
//   shaper is driven by the OR of all lanes, and its output is replicated
//   to every lane.
//
// Ports:
//   CLK                   single rising-edge clock
//   RESET_N               synchronous active-low reset
//   HS_IO_CLK_PAUSE       [LANES] raw asynchronous level requests
//   CLR_STATUS            synchronous clear of STRETCH_STS (set wins)
//   HS_IO_CLK_PAUSE_SYNC  [LANES] registered, shaped pause per lane
//   PAUSE_ANY             registered OR of HS_IO_CLK_PAUSE_SYNC
//   STRETCH_STS           [LANES] sticky "request shorter than MIN_PULSE"
//   dbg_state_o           [2*LANES] FSM state per lane (2 bits per lane;
//                         the shared FSM is replicated when ganged)
//
// Handshake: there is no valid/ready pairing. Every input is a level, and
// every output is a registered level that is updated on each CLK edge.
// ---------------------------------------------------------------------------
module pf_lanectrl_pause_sync_multi #(
   parameter int LANES       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PULSE   = 2,
   parameter int MIN_GAP     = 1,
   parameter int GANG        = 0
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [LANES-1:0]   HS_IO_CLK_PAUSE,
   input  logic               CLR_STATUS,
   output logic [LANES-1:0]   HS_IO_CLK_PAUSE_SYNC,
   output logic               PAUSE_ANY,
   output logic [LANES-1:0]   STRETCH_STS,
   output logic [2*LANES-1:0] dbg_state_o
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ------------------------------------------------------------------
   generate
      if (LANES < 1 || LANES > 16) begin : g_bad_lanes
         $error("LANES must be in 1..16");
      end
      if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("SYNC_STAGES must be in 0..4");
      end
      if (MIN_PULSE < 1 || MIN_PULSE > 15) begin : g_bad_pulse
         $error("MIN_PULSE must be in 1..15");
      end
      if (MIN_GAP < 0 || MIN_GAP > 15) begin : g_bad_gap
         $error("MIN_GAP must be in 0..15");
      end
      if (GANG != 0 && GANG != 1) begin : g_bad_gang
         $error("GANG must be 0 or 1");
      end
   endgenerate

   localparam int NFSM = (GANG != 0) ? 1 : LANES;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PAUSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [3:0] MIN_PULSE_C = 4'(MIN_PULSE);
   localparam logic [3:0] MIN_GAP_C   = 4'(MIN_GAP);
   localparam logic       HAS_GAP     = (MIN_GAP > 0);

   // ------------------------------------------------------------------
   // Synchroniser: SYNC_STAGES flops per lane, or a straight wire
   // ------------------------------------------------------------------
   logic [LANES-1:0] lane_lvl;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign lane_lvl = HS_IO_CLK_PAUSE;
      end else begin : g_sync
         logic [LANES-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge CLK) begin
            if (!RESET_N) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= '0;
               end
            end else begin
               sync_q[0] <= HS_IO_CLK_PAUSE;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign lane_lvl = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Level seen by each FSM: one per lane, or the OR of all lanes when ganged
   logic [NFSM-1:0] fsm_s;

   generate
      if (GANG != 0) begin : g_gang_lvl
         assign fsm_s = |lane_lvl;
      end else begin : g_lane_lvl
         assign fsm_s = lane_lvl;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Pulse-shaping FSMs
   // ------------------------------------------------------------------
   logic [1:0]      state_q [NFSM];
   logic [1:0]      state_d [NFSM];
   logic [3:0]      cnt_q   [NFSM];
   logic [3:0]      cnt_d   [NFSM];
   logic [NFSM-1:0] pend_q;
   logic [NFSM-1:0] pend_d;
   logic [NFSM-1:0] stretch_set;

   always_comb begin
      pend_d      = pend_q;
      stretch_set = '0;
      for (int f = 0; f < NFSM; f++) begin
         state_d[f] = state_q[f];
         cnt_d[f]   = cnt_q[f];

         case (state_q[f])
            ST_IDLE: begin
               if (fsm_s[f]) begin
                  state_d[f] = ST_PAUSE;
                  cnt_d[f]   = 4'd1;
               end
            end

            ST_PAUSE: begin
               if (cnt_q[f] < MIN_PULSE_C) begin
                  // The minimum width is still running. If the request has
                  // already gone, the pause is being stretched.
                  cnt_d[f] = cnt_q[f] + 4'd1;
                  if (!fsm_s[f]) begin
                     stretch_set[f] = 1'b1;
                  end
               end else if (!fsm_s[f]) begin
                  if (HAS_GAP) begin
                     state_d[f] = ST_GAP;
                     cnt_d[f]   = 4'd1;
                  end else begin
                     state_d[f] = ST_IDLE;
                     cnt_d[f]   = 4'd0;
                  end
               end
            end

            ST_GAP: begin
               // Remember any request that shows up during the gap. This
               // keeps a short request from being lost.
               pend_d[f] = pend_q[f] | fsm_s[f];
               if (cnt_q[f] < MIN_GAP_C) begin
                  cnt_d[f] = cnt_q[f] + 4'd1;
               end else begin
                  if (fsm_s[f] || pend_q[f]) begin
                     state_d[f] = ST_PAUSE;
                     cnt_d[f]   = 4'd1;
                  end else begin
                     state_d[f] = ST_IDLE;
                     cnt_d[f]   = 4'd0;
                  end
                  pend_d[f] = 1'b0;
               end
            end

            default: begin
               state_d[f] = ST_IDLE;
               cnt_d[f]   = 4'd0;
               pend_d[f]  = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Map the FSM results onto the lanes
   // ------------------------------------------------------------------
   logic [LANES-1:0] out_d;
   logic [LANES-1:0] sts_set;

   generate
      if (GANG != 0) begin : g_gang_map
         always_comb begin
            out_d      = {LANES{state_d[0] == ST_PAUSE}};
            sts_set    = '0;
            sts_set[0] = stretch_set[0];
         end
         assign dbg_state_o = {LANES{state_q[0]}};
      end else begin : g_lane_map
         always_comb begin
            out_d   = '0;
            sts_set = stretch_set;
            for (int l = 0; l < LANES; l++) begin
               out_d[l] = (state_d[l] == ST_PAUSE);
            end
         end
         always_comb begin
            dbg_state_o = '0;
            for (int l = 0; l < LANES; l++) begin
               dbg_state_o[2*l +: 2] = state_q[l];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   logic [LANES-1:0] out_q;
   logic             any_q;
   logic [LANES-1:0] sts_q;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         for (int f = 0; f < NFSM; f++) begin
            state_q[f] <= ST_IDLE;
            cnt_q[f]   <= 4'd0;
         end
         pend_q <= '0;
         out_q  <= '0;
         any_q  <= 1'b0;
         sts_q  <= '0;
      end else begin
         for (int f = 0; f < NFSM; f++) begin
            state_q[f] <= state_d[f];
            cnt_q[f]   <= cnt_d[f];
         end
         pend_q <= pend_d;
         out_q  <= out_d;
         // PAUSE_ANY comes from the next-state outputs, so it is aligned
         // with the lane outputs on the same cycle.
         any_q  <= |out_d;
         // A new stretch event wins over a clear in the same cycle.
         sts_q  <= sts_set | (sts_q & ~{LANES{CLR_STATUS}});
      end
   end

   assign HS_IO_CLK_PAUSE_SYNC = out_q;
   assign PAUSE_ANY            = any_q;
   assign STRETCH_STS          = sts_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_multi.sv
module tb_pf_lanectrl_pause_sync_multi;

  typedef struct {
    int         dut;
    int         seq;
    logic       rst_n;
    logic [3:0] pause;
    logic       clr;
    logic [3:0] exp_sync;
    logic       exp_any;
    logic [3:0] exp_sts;
  } vec_t;

  vec_t vq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a [4];
  logic [3:0] pause_a [4];
  logic       clr_a   [4];
  logic [3:0] sync_o  [4];
  logic       any_o   [4];
  logic [3:0] sts_o   [4];
  logic [7:0] dbg_o   [4];

  // 0: default lanes, 1: stretch/gap, 2: ganged, 3: bypass
  pf_lanectrl_pause_sync_multi #(.LANES(4), .SYNC_STAGES(2), .MIN_PULSE(2), .MIN_GAP(1), .GANG(0)) u_a (
    .CLK(clk), .RESET_N(rst_n_a[0]), .HS_IO_CLK_PAUSE(pause_a[0]), .CLR_STATUS(clr_a[0]),
    .HS_IO_CLK_PAUSE_SYNC(sync_o[0]), .PAUSE_ANY(any_o[0]), .STRETCH_STS(sts_o[0]), .dbg_state_o(dbg_o[0]));
  pf_lanectrl_pause_sync_multi #(.LANES(4), .SYNC_STAGES(2), .MIN_PULSE(3), .MIN_GAP(4), .GANG(0)) u_b (
    .CLK(clk), .RESET_N(rst_n_a[1]), .HS_IO_CLK_PAUSE(pause_a[1]), .CLR_STATUS(clr_a[1]),
    .HS_IO_CLK_PAUSE_SYNC(sync_o[1]), .PAUSE_ANY(any_o[1]), .STRETCH_STS(sts_o[1]), .dbg_state_o(dbg_o[1]));
  pf_lanectrl_pause_sync_multi #(.LANES(4), .SYNC_STAGES(2), .MIN_PULSE(2), .MIN_GAP(1), .GANG(1)) u_c (
    .CLK(clk), .RESET_N(rst_n_a[2]), .HS_IO_CLK_PAUSE(pause_a[2]), .CLR_STATUS(clr_a[2]),
    .HS_IO_CLK_PAUSE_SYNC(sync_o[2]), .PAUSE_ANY(any_o[2]), .STRETCH_STS(sts_o[2]), .dbg_state_o(dbg_o[2]));
  pf_lanectrl_pause_sync_multi #(.LANES(4), .SYNC_STAGES(0), .MIN_PULSE(2), .MIN_GAP(0), .GANG(0)) u_d (
    .CLK(clk), .RESET_N(rst_n_a[3]), .HS_IO_CLK_PAUSE(pause_a[3]), .CLR_STATUS(clr_a[3]),
    .HS_IO_CLK_PAUSE_SYNC(sync_o[3]), .PAUSE_ANY(any_o[3]), .STRETCH_STS(sts_o[3]), .dbg_state_o(dbg_o[3]));

  // ---------------- driver tasks ----------------
  task automatic add(input int d, input int s, input logic r, input logic [3:0] p,
                     input logic c, input logic [3:0] es, input logic [3:0] et);
    vec_t v;
    v.dut = d; v.seq = s; v.rst_n = r; v.pause = p; v.clr = c;
    v.exp_sync = es; v.exp_any = |es; v.exp_sts = et;
    vq.push_back(v);
  endtask

  task automatic addn(input int n, input int d, input int s, input logic r, input logic [3:0] p,
                      input logic c, input logic [3:0] es, input logic [3:0] et);
    for (int k = 0; k < n; k++) add(d, s, r, p, c, es, et);
  endtask

  task automatic drive(input int d, input logic r, input logic [3:0] p, input logic c);
    for (int i = 0; i < 4; i++) begin
      rst_n_a[i] = (i == d) ? r : 1'b1;
      pause_a[i] = (i == d) ? p : 4'h0;
      clr_a[i]   = (i == d) ? c : 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int seq, input int row,
                     input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s seq %0d row %0d: got %h required %h", nm, seq, row, act, exp);
    end
  endtask

  initial begin
    // --------- vector table (row: inputs before edge, outputs after it) ---------
    // seq 1: lane 0 held 6 cycles, 3-cycle rise latency, 6-cycle output
    addn(2, 0, 1, 1, 4'h1, 0, 4'h0, 4'h0);
    addn(4, 0, 1, 1, 4'h1, 0, 4'h1, 4'h0);
    addn(2, 0, 1, 1, 4'h0, 0, 4'h1, 4'h0);
    addn(2, 0, 1, 1, 4'h0, 0, 4'h0, 4'h0);
    // seq 2: lanes 1 and 2 simultaneously, independent and unarbitrated
    addn(2, 0, 2, 1, 4'h6, 0, 4'h0, 4'h0);
    addn(1, 0, 2, 1, 4'h6, 0, 4'h6, 4'h0);
    addn(2, 0, 2, 1, 4'h0, 0, 4'h6, 4'h0);
    addn(2, 0, 2, 1, 4'h0, 0, 4'h0, 4'h0);
    // seq 3: reset while lane 3 is in PAUSE with cnt=1
    addn(2, 0, 3, 1, 4'h8, 0, 4'h0, 4'h0);
    addn(1, 0, 3, 1, 4'h8, 0, 4'h8, 4'h0);
    addn(1, 0, 3, 0, 4'h8, 0, 4'h0, 4'h0);
    addn(4, 0, 3, 1, 4'h0, 0, 4'h0, 4'h0);
    // seq 4: 1-cycle request on lane 1, MIN_PULSE=3 -> 3-cycle output, sticky status
    addn(1, 1, 4, 1, 4'h2, 0, 4'h0, 4'h0);
    addn(1, 1, 4, 1, 4'h0, 0, 4'h0, 4'h0);
    addn(1, 1, 4, 1, 4'h0, 0, 4'h2, 4'h0);
    addn(2, 1, 4, 1, 4'h0, 0, 4'h2, 4'h2);
    addn(5, 1, 4, 1, 4'h0, 0, 4'h0, 4'h2);
    // seq 5: clear coinciding with a new stretch keeps the bit; plain clear drops it
    addn(1, 1, 5, 1, 4'h2, 0, 4'h0, 4'h2);
    addn(1, 1, 5, 1, 4'h0, 0, 4'h0, 4'h2);
    addn(1, 1, 5, 1, 4'h0, 0, 4'h2, 4'h2);
    addn(1, 1, 5, 1, 4'h0, 1, 4'h2, 4'h2);
    addn(1, 1, 5, 1, 4'h0, 0, 4'h2, 4'h2);
    addn(5, 1, 5, 1, 4'h0, 0, 4'h0, 4'h2);
    addn(1, 1, 5, 1, 4'h0, 1, 4'h0, 4'h0);
    addn(1, 1, 5, 1, 4'h0, 0, 4'h0, 4'h0);
    // seq 6: MIN_GAP=4, second short request during the gap is held pending
    addn(2, 1, 6, 1, 4'h1, 0, 4'h0, 4'h0);
    addn(1, 1, 6, 1, 4'h1, 0, 4'h1, 4'h0);
    addn(1, 1, 6, 1, 4'h0, 0, 4'h1, 4'h0);
    addn(1, 1, 6, 1, 4'h1, 0, 4'h1, 4'h0);
    addn(4, 1, 6, 1, 4'h0, 0, 4'h0, 4'h0);
    addn(1, 1, 6, 1, 4'h0, 0, 4'h1, 4'h0);
    addn(2, 1, 6, 1, 4'h0, 0, 4'h1, 4'h1);
    addn(5, 1, 6, 1, 4'h0, 0, 4'h0, 4'h1);
    addn(1, 1, 6, 1, 4'h0, 1, 4'h0, 4'h0);
    // seq 7: request held high across the gap re-pauses right after it
    addn(2, 1, 7, 1, 4'h8, 0, 4'h0, 4'h0);
    addn(2, 1, 7, 1, 4'h8, 0, 4'h8, 4'h0);
    addn(1, 1, 7, 1, 4'h0, 0, 4'h8, 4'h0);
    addn(1, 1, 7, 1, 4'h8, 0, 4'h8, 4'h0);
    addn(4, 1, 7, 1, 4'h8, 0, 4'h0, 4'h0);
    addn(5, 1, 7, 1, 4'h8, 0, 4'h8, 4'h0);
    addn(2, 1, 7, 1, 4'h0, 0, 4'h8, 4'h0);
    addn(5, 1, 7, 1, 4'h0, 0, 4'h0, 4'h0);
    // seq 8: ganged, request on lane 2 only, then a stretch on lane 3 -> bit 0 only
    addn(2, 2, 8, 1, 4'h4, 0, 4'h0, 4'h0);
    addn(1, 2, 8, 1, 4'h4, 0, 4'hF, 4'h0);
    addn(2, 2, 8, 1, 4'h0, 0, 4'hF, 4'h0);
    addn(2, 2, 8, 1, 4'h0, 0, 4'h0, 4'h0);
    addn(1, 2, 8, 1, 4'h8, 0, 4'h0, 4'h0);
    addn(1, 2, 8, 1, 4'h0, 0, 4'h0, 4'h0);
    addn(1, 2, 8, 1, 4'h0, 0, 4'hF, 4'h0);
    addn(1, 2, 8, 1, 4'h0, 0, 4'hF, 4'h1);
    addn(2, 2, 8, 1, 4'h0, 0, 4'h0, 4'h1);
    addn(1, 2, 8, 1, 4'h0, 1, 4'h0, 4'h0);
    // seq 9: bypass, back-to-back 2-cycle requests with 1-cycle gap
    addn(2, 3, 9, 1, 4'h1, 0, 4'h1, 4'h0);
    addn(1, 3, 9, 1, 4'h0, 0, 4'h0, 4'h0);
    addn(2, 3, 9, 1, 4'h1, 0, 4'h1, 4'h0);
    addn(2, 3, 9, 1, 4'h0, 0, 4'h0, 4'h0);

    // --------- reset state of every instance ---------
    for (int i = 0; i < 4; i++) begin
      rst_n_a[i] = 1'b0; pause_a[i] = 4'h0; clr_a[i] = 1'b0;
    end
    pause_a[0] = 4'hF;
    pause_a[3] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_sync", 0, i, sync_o[i], 4'h0);
      chk("reset_any",  0, i, {3'b000, any_o[i]}, 4'h0);
      chk("reset_sts",  0, i, sts_o[i], 4'h0);
    end
    drive(0, 1'b1, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("post_reset_sync", 0, i, sync_o[i], 4'h0);

    // --------- apply table ---------
    for (int r = 0; r < vq.size(); r++) begin
      drive(vq[r].dut, vq[r].rst_n, vq[r].pause, vq[r].clr);
      @(posedge clk);
      #1;
      chk("sync", vq[r].seq, r, sync_o[vq[r].dut], vq[r].exp_sync);
      chk("pause_any", vq[r].seq, r, {3'b000, any_o[vq[r].dut]}, {3'b000, vq[r].exp_any});
      chk("stretch_sts", vq[r].seq, r, sts_o[vq[r].dut], vq[r].exp_sts);
    end

    // --------- final report ---------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
